multicycle_control: RTL and testbench

Multi-cycle RV32 main control unit: a state machine that sequences each instruction through fetch, decode, execute, memory and write-back steps. It generates the datapath strobes (ALUsrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, ALUOp) plus PC/IR write enables. It handshakes with a variable-latency memory and traps on illegal opcodes or memory timeout. It replaces the single-cycle opcode decoder in front of the shared ALU/register-file datapath.

---
 rtl/ctrl_pkg.sv | 39 +++
 rtl/ctrl_decode.sv | 29 ++
 rtl/multicycle_control.sv | 185 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ctrl_pkg : shared opcodes, state encodings and ALUOp codes for the         |
// |            multi-cycle RV32 control unit.            Revision: 1.0         |
// +--------------------------------------------------------------------------+
package ctrl_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IALU   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_R       = 3'd0,
    CLS_IALU    = 3'd1,
    CLS_LOAD    = 3'd2,
    CLS_STORE   = 3'd3,
    CLS_BRANCH  = 3'd4,
    CLS_JAL     = 3'd5,
    CLS_ILLEGAL = 3'd6
  } opc_class_e;

endpackage
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ctrl_decode : opcode -> instruction-class map; JAL legal only when         |
// |               CTRL_JAL_EN is defined.                Revision: 1.0         |
// +--------------------------------------------------------------------------+
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [6:0]  opc,
  output opc_class_e  cls
);

  always_comb begin
    cls = CLS_ILLEGAL;
    case (opc)
      OPC_R:      cls = CLS_R;
      OPC_IALU:   cls = CLS_IALU;
      OPC_LOAD:   cls = CLS_LOAD;
      OPC_STORE:  cls = CLS_STORE;
      OPC_BRANCH: cls = CLS_BRANCH;
`ifdef CTRL_JAL_EN
      OPC_JAL:    cls = CLS_JAL;
`endif
      default:    cls = CLS_ILLEGAL;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_control : multi-cycle RV32 main control FSM with memory         |
// |   handshake, timeout/illegal traps and retire counter.  Optional JAL       |
// |   support via CTRL_JAL_EN.                           Revision: 1.0         |
// +--------------------------------------------------------------------------+
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opc,
  input  logic             mem_ready,
  input  logic             zero,
  output logic             pc_write,
  output logic             ir_write,
  output logic             alu_src,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             branch,
  output logic [1:0]       alu_op,
  output logic             link,
  output logic             illegal,
  output logic             timeout,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_e            state_q, state_d;
  logic [6:0]        opc_q, opc_d;
  logic              illegal_q, illegal_d;
  logic              timeout_q, timeout_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              retire;
  logic              tmo_hit;
  logic [6:0]        dec_opc;
  opc_class_e        cls;

  // Live opcode is only looked at while decoding; later states use the latched copy.
  assign dec_opc = (state_q == ST_DECODE) ? opc : opc_q;

  ctrl_decode u_decode (
    .opc (dec_opc),
    .cls (cls)
  );

  assign tmo_hit = (MEM_TIMEOUT != 0) && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    opc_d      = opc_q;
    illegal_d  = illegal_q;
    timeout_d  = timeout_q;
    retire     = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    branch     = 1'b0;
    alu_op     = ALU_ADD;
    link       = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end else if (tmo_hit) begin
          timeout_d = 1'b1;
          state_d   = ST_TRAP;
        end
      end
      ST_DECODE: begin
        opc_d = opc;
        if (cls == CLS_ILLEGAL) begin
          illegal_d = 1'b1;
          state_d   = ST_TRAP;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (cls)
          CLS_R: begin
            alu_op  = ALU_FUNCT;
            state_d = ST_WB;
          end
          CLS_IALU: begin
            alu_src = 1'b1;
            alu_op  = ALU_FUNCT;
            state_d = ST_WB;
          end
          CLS_LOAD, CLS_STORE: begin
            alu_src = 1'b1;
            state_d = ST_MEM;
          end
          CLS_BRANCH: begin
            alu_op   = ALU_SUB;
            branch   = 1'b1;
            pc_write = zero;
            retire   = 1'b1;
            state_d  = ST_FETCH;
          end
          CLS_JAL: begin
            pc_write = 1'b1;
            state_d  = ST_WB;
          end
          default: state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        mem_read  = (cls == CLS_LOAD);
        mem_write = (cls != CLS_LOAD);
        if (mem_ready) begin
          if (cls == CLS_LOAD) begin
            state_d = ST_WB;
          end else begin
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
        end else if (tmo_hit) begin
          timeout_d = 1'b1;
          state_d   = ST_TRAP;
        end
      end
      ST_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (cls == CLS_LOAD);
`ifdef CTRL_JAL_EN
        link       = (cls == CLS_JAL);
`endif
        retire     = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase

    // Wait count only survives a cycle that stays in the same access state unanswered.
    if (((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_ready && (state_d == state_q))
      wait_d = wait_q + 1'b1;
    else
      wait_d = '0;

    retired_d = retire ? retired_q + 1'b1 : retired_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      opc_q     <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  assign illegal = illegal_q;
  assign timeout = timeout_q;
  assign state   = state_q;
  assign retired = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_multicycle_control : directed self-checking bench for                   |
// |   multicycle_control (MEM_TIMEOUT=4).                Revision: 1.0         |
// +--------------------------------------------------------------------------+
module tb_multicycle_control;

  logic        clk;
  logic        rst_n;
  logic [6:0]  opc;
  logic        mem_ready;
  logic        zero;
  logic        pc_write, ir_write, alu_src, mem_to_reg, reg_write;
  logic        mem_read, mem_write, branch, link, illegal, timeout;
  logic [1:0]  alu_op;
  logic [2:0]  state;
  logic [31:0] retired;

  int nvec = 0;
  int nerr = 0;

  multicycle_control #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opc        (opc),
    .mem_ready  (mem_ready),
    .zero       (zero),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .alu_src    (alu_src),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .branch     (branch),
    .alu_op     (alu_op),
    .link       (link),
    .illegal    (illegal),
    .timeout    (timeout),
    .state      (state),
    .retired    (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_write, ir_write, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op, link}
  wire [10:0] strobes = {pc_write, ir_write, alu_src, mem_to_reg, reg_write,
                         mem_read, mem_write, branch, alu_op, link};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; opc = 7'b0110011; mem_ready = 1'b0; zero = 1'b0;
    #1;
    step(); step();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_strobes", 32'(strobes), 32'b000_0010_0000);
    chk("rst_flags", {30'd0, illegal, timeout}, 32'd0);
    chk("rst_retired", retired, 32'd0);
    rst_n = 1'b1;

    // R-type, zero-wait memory
    mem_ready = 1'b1; #1;
    chk("r_fetch", 32'(strobes), 32'b110_0010_0000);
    step(); chk("r_decode_state", 32'(state), 32'd1);
    chk("r_decode_strobes", 32'(strobes), 32'd0);
    step(); chk("r_exec_state", 32'(state), 32'd2);
    chk("r_exec_strobes", 32'(strobes), 32'b000_0000_0100);
    step(); chk("r_wb_state", 32'(state), 32'd4);
    chk("r_wb_strobes", 32'(strobes), 32'b000_0100_0000);
    step(); chk("r_done_state", 32'(state), 32'd0);
    chk("r_retired", retired, 32'd1);

    // Load with three MEM wait cycles (ready on the fourth = timeout boundary)
    opc = 7'b0000011; #1;
    step(); step();
    chk("ld_exec_strobes", 32'(strobes), 32'b001_0000_0000);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ld_mem_wait_state", 32'(state), 32'd3);
      chk("ld_mem_wait_strobes", 32'(strobes), 32'b000_0010_0000);
    end
    step(); mem_ready = 1'b1; #1;
    chk("ld_mem_last_state", 32'(state), 32'd3);
    chk("ld_mem_last_read", 32'(mem_read), 32'd1);
    step(); chk("ld_wb_state", 32'(state), 32'd4);
    chk("ld_wb_strobes", 32'(strobes), 32'b000_1100_0000);
    step(); chk("ld_done_state", 32'(state), 32'd0);
    chk("ld_retired", retired, 32'd2);

    // Store
    opc = 7'b0100011; #1;
    step(); step();
    chk("st_exec_strobes", 32'(strobes), 32'b001_0000_0000);
    step(); chk("st_mem_strobes", 32'(strobes), 32'b000_0001_0000);
    step(); chk("st_done_state", 32'(state), 32'd0);
    chk("st_retired", retired, 32'd3);

    // Branch taken then not taken
    opc = 7'b1100011; zero = 1'b1; #1;
    step(); step();
    chk("br1_exec_strobes", 32'(strobes), 32'b100_0000_1010);
    step(); chk("br1_state", 32'(state), 32'd0);
    zero = 1'b0; #1;
    step(); step();
    chk("br0_exec_strobes", 32'(strobes), 32'b000_0000_1010);
    step(); chk("br0_state", 32'(state), 32'd0);
    chk("br_retired", retired, 32'd5);

    // Fetch timeout: four unanswered cycles
    mem_ready = 1'b0; #1;
    step(); step(); step();
    chk("tmo_pre_state", 32'(state), 32'd0);
    chk("tmo_pre_flag", 32'(timeout), 32'd0);
    step();
    chk("tmo_state", 32'(state), 32'd5);
    chk("tmo_flags", {30'd0, illegal, timeout}, 32'd1);
    chk("tmo_retired", retired, 32'd5);
    rst_n = 1'b0; #1;
    chk("tmo_rst_state", 32'(state), 32'd0);
    chk("tmo_rst_retired", retired, 32'd0);
    step(); rst_n = 1'b1; mem_ready = 1'b1;

    // Illegal opcode, held in TRAP
    opc = 7'b1111111; #1;
    step(); step();
    chk("ill_state", 32'(state), 32'd5);
    chk("ill_flags", {30'd0, illegal, timeout}, 32'd2);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("ill_hold_strobes", {21'd0, strobes}, 32'd0);
      chk("ill_hold_state", 32'(state), 32'd5);
    end
    rst_n = 1'b0; #1;
    chk("ill_rst_state", 32'(state), 32'd0);
    chk("ill_rst_flag", 32'(illegal), 32'd0);
    step(); rst_n = 1'b1;

    // JAL
    opc = 7'b1101111; #1;
    step(); step();
`ifdef CTRL_JAL_EN
    chk("jal_exec_state", 32'(state), 32'd2);
    chk("jal_exec_pcw", 32'(pc_write), 32'd1);
    step();
    chk("jal_wb_strobes", 32'(strobes), 32'b000_0100_0001);
    step(); chk("jal_retired", retired, 32'd1);
`else
    chk("jal_ill_state", 32'(state), 32'd5);
    chk("jal_ill_flag", 32'(illegal), 32'd1);
    chk("jal_link", 32'(link), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
